// File: rtl/paddle_ctrl.sv
// paddle_ctrl: paddle position / speed FSM and ball-launch request register.
//   Moves the paddle centre once per frame_tick from the debounced keys,
//   with optional hold-to-accelerate, clamped to the playfield borders.
//   Latches a launch request from the fire edges until the ball engine accepts it.
// Optional feature macro: PADDLE_ACCEL_EN (defined = speed ramps while a key is
//   held; undefined = constant SPEED_MIN, no accel counter).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   frame_tick                      1-cycle pulse per video frame
//   left_n, right_n                 debounced keys, 0 = pressed
//   fire1_edge, fire2_edge          press pulses: launch right / left
//   game_active                     enables motion and launch
//   recenter                        pulse: paddle back to INIT_X, idle
//   launch_ready                    ball engine accepts the launch
//   paddle_x, paddle_speed, moving  paddle state (registered)
//   launch_valid, launch_dir_x      launch request and direction (registered)
module paddle_ctrl #(
   parameter int unsigned XW           = 10,
   parameter int unsigned LEFT_BORDER  = 10,
   parameter int unsigned RIGHT_BORDER = 630,
   parameter int unsigned PADDLE_WIDTH = 80,
   parameter int unsigned INIT_X       = 320,
   parameter int unsigned SPEED_MIN    = 2,
   parameter int unsigned SPEED_MAX    = 8,
   parameter int unsigned ACCEL_FRAMES = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_tick,
   input  logic          left_n,
   input  logic          right_n,
   input  logic          fire1_edge,
   input  logic          fire2_edge,
   input  logic          game_active,
   input  logic          recenter,
   input  logic          launch_ready,
   output logic [XW-1:0] paddle_x,
   output logic [3:0]    paddle_speed,
   output logic          moving,
   output logic          launch_valid,
   output logic          launch_dir_x
);

   localparam int unsigned SW     = 4;
   localparam int unsigned EW     = XW + 1;
   localparam int unsigned HALF_W = PADDLE_WIDTH / 2;
   // Legal centre range; edge math done in EW bits so nothing can wrap.
   localparam logic [EW-1:0] LIM_L = EW'(LEFT_BORDER + HALF_W);
   localparam logic [EW-1:0] LIM_R = EW'(RIGHT_BORDER - HALF_W);

   // Elaboration-time sanity check of the parameter set.
   if (SPEED_MAX > 15 || SPEED_MIN > SPEED_MAX || SPEED_MIN == 0 ||
       ACCEL_FRAMES == 0 || (PADDLE_WIDTH % 2) != 0) begin : g_bad_cfg
      $error("paddle_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_L = 2'd1,
      MOVE_R = 2'd2
   } state_t;

   state_t        state_q, state_n;
   logic [XW-1:0] x_q, x_n;
   logic [SW-1:0] spd_q, spd_n;
   logic          moving_q, moving_n;
   logic          lv_q, lv_n;
   logic          dir_q, dir_n;

   logic [SW-1:0] move_spd;
   logic [EW-1:0] ext_x;
   logic [EW-1:0] ext_spd;
   logic          key_l;
   logic          key_r;

`ifdef PADDLE_ACCEL_EN
   localparam int unsigned CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
   logic [CW-1:0] cnt_q, cnt_n;
`endif

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= XW'(INIT_X);
         spd_q    <= '0;
         moving_q <= 1'b0;
         lv_q     <= 1'b0;
         dir_q    <= 1'b0;
`ifdef PADDLE_ACCEL_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_n;
         x_q      <= x_n;
         spd_q    <= spd_n;
         moving_q <= moving_n;
         lv_q     <= lv_n;
         dir_q    <= dir_n;
`ifdef PADDLE_ACCEL_EN
         cnt_q    <= cnt_n;
`endif
      end
   end

   // Next-state: launch handshake every cycle, motion only on frame ticks.
   always_comb begin
      state_n  = state_q;
      x_n      = x_q;
      spd_n    = spd_q;
      lv_n     = lv_q;
      dir_n    = dir_q;
`ifdef PADDLE_ACCEL_EN
      cnt_n    = cnt_q;
`endif
      move_spd = SW'(SPEED_MIN);
      ext_x    = EW'(x_q);
      ext_spd  = '0;
      key_l    = ~left_n & right_n;
      key_r    = ~right_n & left_n;

      // A pending request blocks new edges; dir stays frozen until accepted.
      if (lv_q) begin
         if (launch_ready) begin
            lv_n = 1'b0;
         end
      end else if (game_active && (fire1_edge || fire2_edge)) begin
         lv_n  = 1'b1;
         dir_n = fire1_edge;
      end

      if (recenter) begin
         state_n = IDLE;
         x_n     = XW'(INIT_X);
         spd_n   = '0;
`ifdef PADDLE_ACCEL_EN
         cnt_n   = '0;
`endif
      end else if (frame_tick) begin
         if (!game_active || !(key_l || key_r)) begin
            state_n = IDLE;
            spd_n   = '0;
`ifdef PADDLE_ACCEL_EN
            cnt_n   = '0;
`endif
         end else begin
            state_n = key_l ? MOVE_L : MOVE_R;
`ifdef PADDLE_ACCEL_EN
            // Same direction as last tick: ramp speed every ACCEL_FRAMES ticks.
            if (state_q == state_n) begin
               move_spd = spd_q;
               if (cnt_q == CW'(ACCEL_FRAMES - 1)) begin
                  cnt_n = '0;
                  if (spd_q < SW'(SPEED_MAX)) begin
                     move_spd = spd_q + SW'(1);
                  end
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end else begin
               cnt_n = '0;
            end
`endif
            spd_n   = move_spd;
            ext_spd = EW'(move_spd);
            // Clamp tests rearranged so the subtraction never underflows.
            if (key_l) begin
               x_n = (ext_x < LIM_L + ext_spd) ? XW'(LIM_L) : XW'(ext_x - ext_spd);
            end else begin
               x_n = (ext_x + ext_spd > LIM_R) ? XW'(LIM_R) : XW'(ext_x + ext_spd);
            end
         end
      end

      moving_n = (state_n != IDLE);
   end

   assign paddle_x     = x_q;
   assign paddle_speed = spd_q;
   assign moving       = moving_q;
   assign launch_valid = lv_q;
   assign launch_dir_x = dir_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: scoreboard bench for paddle_ctrl. A behavioural model
// pushes the expected outputs for each driven cycle; tests pop and compare.
module tb_paddle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       left_n = 1'b1;
   logic       right_n = 1'b1;
   logic       fire1_edge = 1'b0;
   logic       fire2_edge = 1'b0;
   logic       game_active = 1'b1;
   logic       recenter = 1'b0;
   logic       launch_ready = 1'b0;
   logic [9:0] paddle_x;
   logic [3:0] paddle_speed;
   logic       moving;
   logic       launch_valid;
   logic       launch_dir_x;

   paddle_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .left_n       (left_n),
      .right_n      (right_n),
      .fire1_edge   (fire1_edge),
      .fire2_edge   (fire2_edge),
      .game_active  (game_active),
      .recenter     (recenter),
      .launch_ready (launch_ready),
      .paddle_x     (paddle_x),
      .paddle_speed (paddle_speed),
      .moving       (moving),
      .launch_valid (launch_valid),
      .launch_dir_x (launch_dir_x)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] x;
      logic [3:0] spd;
      logic       mv;
      logic       lv;
      logic       dir;
   } obs_t;

   localparam obs_t RESET_OBS = '{x: 10'd320, spd: 4'd0, mv: 1'b0, lv: 1'b0, dir: 1'b0};

   obs_t sb[$];
   obs_t e;
   obs_t o;
   int   n_checks = 0;
   int   n_err = 0;

   // Reference model state.
   int m_x = 320;
   int m_spd = 0;
   int m_cnt = 0;
   int m_st = 0;   // 0 idle, 1 left, 2 right
   bit m_lv = 1'b0;
   bit m_dir = 1'b0;

   function automatic string fmt(obs_t v);
      return $sformatf("x=%0d spd=%0d mv=%b lv=%b dir=%b", v.x, v.spd, v.mv, v.lv, v.dir);
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s = '{x: paddle_x, spd: paddle_speed, mv: moving, lv: launch_valid, dir: launch_dir_x};
      return s;
   endfunction

   task automatic model_reset();
      m_x = 320; m_spd = 0; m_cnt = 0; m_st = 0; m_lv = 1'b0; m_dir = 1'b0;
   endtask

   // Model one clock with the inputs now on the pins, push expectation, clock DUT.
   task automatic drive_cycle();
      int d;
      obs_t p;
      if (m_lv) begin
         if (launch_ready) m_lv = 1'b0;
      end else if (game_active && (fire1_edge || fire2_edge)) begin
         m_lv  = 1'b1;
         m_dir = fire1_edge;
      end
      if (recenter) begin
         m_x = 320; m_spd = 0; m_st = 0; m_cnt = 0;
      end else if (frame_tick) begin
         d = (!left_n && right_n) ? 1 : ((left_n && !right_n) ? 2 : 0);
         if (!game_active || d == 0) begin
            m_st = 0; m_spd = 0; m_cnt = 0;
         end else begin
            if (d != m_st) begin
               m_st = d; m_spd = 2; m_cnt = 0;
            end
`ifdef PADDLE_ACCEL_EN
            else begin
               m_cnt++;
               if (m_cnt == 4) begin
                  m_cnt = 0;
                  if (m_spd < 8) m_spd++;
               end
            end
`endif
            if (d == 1) begin
               m_x = m_x - m_spd;
               if (m_x - 40 < 10) m_x = 50;
            end else begin
               m_x = m_x + m_spd;
               if (m_x + 40 > 630) m_x = 590;
            end
         end
      end
      p = '{x: 10'(m_x), spd: 4'(m_spd), mv: (m_st != 0), lv: m_lv, dir: m_dir};
      sb.push_back(p);
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      fire1_edge = 1'b0;
      fire2_edge = 1'b0;
      recenter   = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      o = sample();
      n_checks++;
      if (o !== RESET_OBS) begin
         n_err++; $display("FAIL reset_values: got %s, expected %s", fmt(o), fmt(RESET_OBS));
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL idle_tick%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (paddle_x !== 10'd320 || paddle_speed !== 4'd0 || moving !== 1'b0) begin
         n_err++; $display("FAIL idle_final: got x=%0d spd=%0d mv=%b, expected x=320 spd=0 mv=0",
                           paddle_x, paddle_speed, moving);
      end
   endtask

   task automatic test_accel_left();
      int exp_x;
`ifdef PADDLE_ACCEL_EN
      exp_x = 296;
`else
      exp_x = 302;
`endif
      left_n = 1'b0;
      for (int i = 0; i < 9; i++) begin
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL accel_left%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (paddle_x !== 10'(exp_x)) begin
         n_err++; $display("FAIL accel_left_pos: got x=%0d, expected x=%0d", paddle_x, exp_x);
      end
      left_n = 1'b1;
      frame_tick = 1'b1;
      drive_cycle();
      o = sample(); e = sb.pop_front(); n_checks++;
      if (o !== e) begin
         n_err++; $display("FAIL accel_release: got %s, expected %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_reverse();
      recenter = 1'b1;
      drive_cycle();
      void'(sb.pop_front());
      left_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 6) begin left_n = 1'b1; right_n = 1'b0; end
         if (i == 7) begin left_n = 1'b0; right_n = 1'b0; end
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL reverse%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
         if (i == 6) begin
            n_checks++;
            if (paddle_speed !== 4'd2 || moving !== 1'b1) begin
               n_err++; $display("FAIL reverse_first_right: got spd=%0d mv=%b, expected spd=2 mv=1",
                                 paddle_speed, moving);
            end
         end
      end
      n_checks++;
      if (paddle_speed !== 4'd0 || moving !== 1'b0) begin
         n_err++; $display("FAIL both_keys_idle: got spd=%0d mv=%b, expected spd=0 mv=0",
                           paddle_speed, moving);
      end
      left_n = 1'b1; right_n = 1'b1;
   endtask

   task automatic test_right_clamp();
      recenter = 1'b1;
      drive_cycle();
      void'(sb.pop_front());
      right_n = 1'b0;
      for (int i = 0; i < 150; i++) begin
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e || paddle_x > 10'd590) begin
            n_err++; $display("FAIL right_clamp%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (paddle_x !== 10'd590 || moving !== 1'b1) begin
         n_err++; $display("FAIL right_clamp_final: got x=%0d mv=%b, expected x=590 mv=1",
                           paddle_x, moving);
      end
      right_n = 1'b1;
   endtask

   task automatic test_game_inactive();
      logic [9:0] held_x;
      left_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin game_active = 1'b0; fire1_edge = 1'b1; end
         held_x = paddle_x;
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL inactive%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (paddle_x !== held_x || paddle_speed !== 4'd0 || moving !== 1'b0 || launch_valid !== 1'b0) begin
         n_err++; $display("FAIL inactive_hold: got x=%0d spd=%0d mv=%b lv=%b, expected x=%0d spd=0 mv=0 lv=0",
                           paddle_x, paddle_speed, moving, launch_valid, held_x);
      end
      game_active = 1'b1;
      left_n = 1'b1;
   endtask

   task automatic test_launch();
      launch_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) begin fire1_edge = 1'b1; fire2_edge = 1'b1; end
         if (i == 3) fire2_edge = 1'b1;
         launch_ready = (i == 5 || i == 8);
         if (i == 7) fire2_edge = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL launch%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
         if (i == 4) begin
            n_checks++;
            if (launch_valid !== 1'b1 || launch_dir_x !== 1'b1) begin
               n_err++; $display("FAIL launch_held: got lv=%b dir=%b, expected lv=1 dir=1",
                                 launch_valid, launch_dir_x);
            end
         end
         if (i == 5) begin
            n_checks++;
            if (launch_valid !== 1'b0) begin
               n_err++; $display("FAIL launch_clear: got lv=%b, expected lv=0", launch_valid);
            end
         end
      end
      launch_ready = 1'b0;
   endtask

   task automatic test_recenter_reset();
      left_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) recenter = 1'b1;
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL recenter%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (paddle_x !== 10'd320 || paddle_speed !== 4'd0 || moving !== 1'b0) begin
         n_err++; $display("FAIL recenter_final: got x=%0d spd=%0d mv=%b, expected x=320 spd=0 mv=0",
                           paddle_x, paddle_speed, moving);
      end
      fire2_edge = 1'b1;
      for (int i = 0; i < 5; i++) begin
         frame_tick = 1'b1;
         drive_cycle();
         o = sample(); e = sb.pop_front(); n_checks++;
         if (o !== e) begin
            n_err++; $display("FAIL pre_reset%0d: got %s, expected %s", i, fmt(o), fmt(e));
         end
      end
      rst_n = 1'b0;
      #2;
      o = sample(); n_checks++;
      if (o !== RESET_OBS) begin
         n_err++; $display("FAIL async_reset: got %s, expected %s", fmt(o), fmt(RESET_OBS));
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame_tick = 1'b1;
      drive_cycle();
      o = sample(); e = sb.pop_front(); n_checks++;
      if (o !== e) begin
         n_err++; $display("FAIL post_reset: got %s, expected %s", fmt(o), fmt(e));
      end
      left_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_accel_left();
      test_reverse();
      test_right_clamp();
      test_game_inactive();
      test_launch();
      test_recenter_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
